// File: rtl/image_window_fetch.sv
// 3x3 convolution window fetcher: walks an image page with stride and zero padding,
// issues registered page reads and presents each assembled window over valid/ready.
module image_window_fetch #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 640,
  parameter int STRIDE = 1,
  parameter int PAD    = 1,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] page_addr,
  output logic              page_rd,
  input  logic [7:0]        page_data,
  output logic [71:0]       win_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [9:0]        win_x,
  output logic [9:0]        win_y
);

  localparam int OUT_W = (IMG_W + 2*PAD - 3) / STRIDE + 1;
  localparam int OUT_H = (IMG_H + 2*PAD - 3) / STRIDE + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0] state;
  logic [9:0] ox, oy;
  logic [3:0] tap;
  logic       cap_valid;
  logic       cap_pad;
  logic [3:0] cap_tap;

  logic       ox_wrap, last_win;
  logic       issue;
  logic [9:0] nx_ox, nx_oy;
  logic [3:0] nx_tap;
  int         kx, ky, px, py, addr_full;
  logic       in_range;

  assign ox_wrap  = (ox == 10'(OUT_W - 1));
  assign last_win = ox_wrap && (oy == 10'(OUT_H - 1));

  // The read for a tap is set up one edge ahead, so page_rd/page_addr are
  // registered yet line up with the tap counter seen in the same cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    issue  = 1'b0;
    nx_ox  = ox;
    nx_oy  = oy;
    nx_tap = tap + 4'd1;
    case (state)
      S_IDLE: begin
        if (start) begin
          issue  = 1'b1;
          nx_ox  = '0;
          nx_oy  = '0;
          nx_tap = '0;
        end
      end
      S_FETCH: issue = (tap != 4'd8);
      S_PRESENT: begin
        if (win_ready && !last_win) begin
          issue  = 1'b1;
          nx_tap = '0;
          if (ox_wrap) begin
            nx_ox = '0;
            nx_oy = oy + 10'd1;
          end else begin
            nx_ox = ox + 10'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    kx        = int'(nx_tap) % 3;
    ky        = int'(nx_tap) / 3;
    px        = int'(nx_ox) * STRIDE + kx - PAD;
    py        = int'(nx_oy) * STRIDE + ky - PAD;
    in_range  = (px >= 0) && (px < IMG_W) && (py >= 0) && (py < IMG_H);
    addr_full = py * IMG_W + px;
  end

  assign win_x = ox;
  assign win_y = oy;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      page_rd   <= 1'b0;
      page_addr <= '0;
      win_data  <= '0;
      win_valid <= 1'b0;
      ox        <= '0;
      oy        <= '0;
      tap       <= '0;
      cap_valid <= 1'b0;
      cap_pad   <= 1'b0;
      cap_tap   <= '0;
    end else begin
      // Tap index and pad flag travel one cycle behind the read, with the data.
      cap_valid <= (state == S_FETCH);
      cap_tap   <= tap;
      cap_pad   <= ~page_rd;
      for (int t = 0; t < 9; t++) begin
        if (cap_valid && cap_tap == 4'(t))
          win_data[t*8 +: 8] <= cap_pad ? 8'h00 : page_data;
      end

      if (issue) begin
        page_rd <= in_range;
        if (in_range) page_addr <= ADDR_W'(addr_full);
        ox  <= nx_ox;
        oy  <= nx_oy;
        tap <= nx_tap;
      end else begin
        page_rd <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (tap == 4'd8) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          state     <= S_PRESENT;
          win_valid <= 1'b1;
        end
        S_PRESENT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last_win) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_window_fetch.sv
// Directed bench for image_window_fetch: a 4x4 page for windowing and handshake,
// a 16x16 stride-2 page for a whole frame, and a 640x640 stride-2 page for addressing.
module tb_image_window_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  // Page contents are a fixed function of the address; equals the address below 256.
  function automatic logic [7:0] fold(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
  endfunction

  // ---------------- DUT A: 4x4, stride 1 ----------------
  logic        a_start, a_busy, a_done, a_rd, a_valid, a_ready;
  logic [7:0]  a_addr, a_pdata;
  logic [71:0] a_data;
  logic [9:0]  a_x, a_y;
  logic [18:0] a_log[$];
  int          a_done_cnt = 0;
  int          a_mark;

  image_window_fetch #(.IMG_W(4), .IMG_H(4), .STRIDE(1), .PAD(1), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .page_addr(a_addr), .page_rd(a_rd), .page_data(a_pdata),
    .win_data(a_data), .win_valid(a_valid), .win_ready(a_ready),
    .win_x(a_x), .win_y(a_y));

  always @(posedge clk) begin
    if (a_rd) begin
      a_pdata <= fold(19'(a_addr));
      a_log.push_back(19'(a_addr));
    end
    if (a_done) a_done_cnt++;
  end

  // ---------------- DUT B: 16x16, stride 2 ----------------
  logic        b_start, b_busy, b_done, b_rd, b_valid, b_ready;
  logic [7:0]  b_addr, b_pdata;
  logic [71:0] b_data, b_last;
  logic [9:0]  b_x, b_y;
  int          b_wins = 0;
  int          b_max  = 0;

  image_window_fetch #(.IMG_W(16), .IMG_H(16), .STRIDE(2), .PAD(1), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .page_addr(b_addr), .page_rd(b_rd), .page_data(b_pdata),
    .win_data(b_data), .win_valid(b_valid), .win_ready(b_ready),
    .win_x(b_x), .win_y(b_y));

  always @(posedge clk) begin
    if (b_rd) begin
      b_pdata <= fold(19'(b_addr));
      if (int'(b_addr) > b_max) b_max = int'(b_addr);
    end
    if (b_valid && b_ready) begin
      b_wins++;
      b_last = b_data;
    end
  end

  // ---------------- DUT C: 640x640, stride 2 ----------------
  logic        c_start, c_busy, c_done, c_rd, c_valid, c_ready;
  logic [18:0] c_addr;
  logic [7:0]  c_pdata;
  logic [71:0] c_data;
  logic [9:0]  c_x, c_y;
  logic [18:0] c_log[$];
  int          c_mark;

  image_window_fetch #(.IMG_W(640), .IMG_H(640), .STRIDE(2), .PAD(1), .ADDR_W(19)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
    .page_addr(c_addr), .page_rd(c_rd), .page_data(c_pdata),
    .win_data(c_data), .win_valid(c_valid), .win_ready(c_ready),
    .win_x(c_x), .win_y(c_y));

  always @(posedge clk) begin
    if (c_rd) begin
      c_pdata <= fold(c_addr);
      c_log.push_back(c_addr);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] pack_a(input int from);
    logic [71:0] r = '0;
    for (int i = 0; i < 9; i++)
      if (from + i < a_log.size()) r[i*8 +: 8] = a_log[from + i][7:0];
    return r;
  endfunction

  // Called on the first FETCH cycle of a window; returns once it is presented.
  task automatic fetch_a(input int ex, input int ey);
    int n = 0;
    a_mark = a_log.size();
    while (a_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("a_latency(%0d,%0d)", ex, ey), 72'(n), 72'(10));
    check($sformatf("a_win_x(%0d,%0d)", ex, ey), 72'(a_x), 72'(ex));
    check($sformatf("a_win_y(%0d,%0d)", ex, ey), 72'(a_y), 72'(ey));
  endtask

  task automatic wait_c(input string tag);
    int n = 0;
    c_mark = c_log.size();
    while (c_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 72'(n), 72'(10));
  endtask

  localparam logic [71:0] W00 = {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] W20 = {8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] W11 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] W33 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd14, 8'd0, 8'd11, 8'd10};
  localparam logic [71:0] WB_LAST = {8'd255, 8'd254, 8'd253, 8'd239, 8'd238, 8'd237,
                                     8'd223, 8'd222, 8'd221};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b0;
    a_start = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_ready = 1'b1;
    c_start = 1'b0; c_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Reset state
    check("rst_busy", 72'(a_busy), 72'(0));
    check("rst_rd", 72'(a_rd), 72'(0));
    check("rst_valid", 72'(a_valid), 72'(0));
    check("rst_data", a_data, 72'(0));

    // Reset in the middle of a fetch while a read is outstanding
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (4) tick();
    check("mid_rd_high", 72'(a_rd), 72'(1));
    rst = 1'b0;
    tick();
    check("mrst_busy", 72'(a_busy), 72'(0));
    check("mrst_done", 72'(a_done), 72'(0));
    check("mrst_rd", 72'(a_rd), 72'(0));
    check("mrst_valid", 72'(a_valid), 72'(0));
    check("mrst_addr", 72'(a_addr), 72'(0));
    check("mrst_data", a_data, 72'(0));
    check("mrst_xy", 72'({a_x, a_y}), 72'(0));
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (a_rd !== 1'b0 || a_valid !== 1'b0) cnt++;
    end
    check("post_rst_quiet", 72'(cnt), 72'(0));

    // Full 4x4 frame
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("start_busy", 72'(a_busy), 72'(1));

    fetch_a(0, 0);
    check("w00_data", a_data, W00);
    check("w00_nreads", 72'(a_log.size() - a_mark), 72'(4));
    check("w00_reads", pack_a(a_mark), 72'h05040100);
    tick();

    fetch_a(1, 0);
    tick();
    a_ready = 1'b0;

    // Backpressure on window (2,0); a start pulse here must be ignored
    fetch_a(2, 0);
    check("w20_data", a_data, W20);
    for (int k = 0; k < 5; k++) begin
      a_start = (k == 1);
      tick();
      check("bp_valid", 72'(a_valid), 72'(1));
      check("bp_data", a_data, W20);
      check("bp_xy", 72'({a_x, a_y}), 72'({10'd2, 10'd0}));
      check("bp_rd", 72'(a_rd), 72'(0));
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    tick();
    check("bp_accept", 72'(a_valid), 72'(0));

    fetch_a(3, 0);
    tick();
    fetch_a(0, 1);
    tick();
    fetch_a(1, 1);
    check("w11_data", a_data, W11);
    check("w11_nreads", 72'(a_log.size() - a_mark), 72'(9));
    check("w11_reads", pack_a(a_mark), W11);
    tick();
    for (int idx = 6; idx < 15; idx++) begin
      fetch_a(idx % 4, idx / 4);
      tick();
    end
    fetch_a(3, 3);
    check("w33_data", a_data, W33);
    check("w33_busy", 72'(a_busy), 72'(1));
    tick();
    check("done_pulse", 72'(a_done), 72'(1));
    check("done_busy", 72'(a_busy), 72'(0));
    check("done_valid", 72'(a_valid), 72'(0));
    tick();
    check("done_clear", 72'(a_done), 72'(0));
    repeat (30) tick();
    check("done_once", 72'(a_done_cnt), 72'(1));
    check("idle_busy", 72'(a_busy), 72'(0));

    // 16x16 stride-2 frame: 8x8 windows
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cnt = 0;
    while (b_done !== 1'b1 && cnt < 2000) begin
      tick();
      cnt++;
    end
    check("b_done_seen", 72'(b_done), 72'(1));
    check("b_wins", 72'(b_wins), 72'(64));
    check("b_max_addr", 72'(b_max), 72'(255));
    check("b_last_data", b_last, WB_LAST);
    check("b_last_xy", 72'({b_x, b_y}), 72'({10'd7, 10'd7}));

    // 640x640 stride-2: full-width addressing of the first two windows
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    wait_c("c_w00_latency");
    check("c_w00_nreads", 72'(c_log.size() - c_mark), 72'(4));
    check("c_w00_rd2", 72'(c_log[c_mark + 2]), 72'(640));
    check("c_w00_rd3", 72'(c_log[c_mark + 3]), 72'(641));
    check("c_w00_data", c_data, {8'h83, 8'h82, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;
    wait_c("c_w10_latency");
    check("c_w10_nreads", 72'(c_log.size() - c_mark), 72'(6));
    check("c_w10_rd5", 72'(c_log[c_mark + 5]), 72'(643));
    check("c_w10_x", 72'(c_x), 72'(1));
    check("c_w10_tap8", 72'(c_data[71:64]), 72'(fold(19'd643)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
